// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-channel round-robin arbiter.
//   N_CH        : number of requesters / multiplexer inputs
//   IDX_W       : width of a channel index
//   CNT_W       : width of the grant hold counter
//   arb_state_t : arbiter FSM state
//   ch_idx_t    : channel index / multiplexer select
package arb_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [IDX_W-1:0] ch_idx_t;

endpackage

// File: rtl/rr_pick4.sv
// Circular first-set search over four request lines.
//   req   : request vector
//   start : index where the search begins (wraps mod 4)
//   idx   : first requesting index at or after start (start when none)
//   any   : high when any request bit is set
module rr_pick4
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic [1:0] idx,
    output logic       any
);

    // Walk start, start+1, ... ; the 2-bit sum wraps naturally.
    always_comb begin
        idx = start;
        any = 1'b0;
        for (int off = 0; off < int'(N_CH); off++) begin
            if (!any && req[ch_idx_t'(start + ch_idx_t'(off))]) begin
                idx = ch_idx_t'(start + ch_idx_t'(off));
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with a bounded grant hold.
// Drives the 2-bit select of a downstream 4:1 channel multiplexer and a
// one-hot grant back to the requesters.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req       : request lines, req[i] for requester i
//   gnt       : registered one-hot grant, zero when no owner
//   sel       : registered owner index (multiplexer select)
//   gnt_valid : registered, high while a grant is held
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       gnt_valid
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = {CNT_W{1'b1}};

    arb_state_t       state, next_state;
    ch_idx_t          owner, next_owner;
    ch_idx_t          ptr, next_ptr;
    logic [CNT_W-1:0] hold_cnt, next_hold_cnt;
    logic [3:0]       next_gnt;

    ch_idx_t    pick_start;
    ch_idx_t    pick_idx;
    logic       pick_any;
    logic [3:0] owner_mask;
    logic       others;

    // Idle searches from ptr; a handover searches from the slot after the owner.
    assign pick_start = (state == IDLE) ? ptr : ch_idx_t'(owner + 2'd1);
    assign owner_mask = 4'(4'b0001 << owner);
    assign others     = |(req & ~owner_mask);

    rr_pick4 u_pick (
        .req   (req),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Next-state, hold counter and output decode.
    always_comb begin
        next_state    = state;
        next_owner    = owner;
        next_ptr      = ptr;
        next_hold_cnt = hold_cnt;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    next_owner    = pick_idx;
                    next_ptr      = ch_idx_t'(pick_idx + 2'd1);
                    next_hold_cnt = '0;
                    next_state    = GRANT;
                end
            end
            GRANT: begin
                if (req[owner] && (!others || hold_cnt < HOLD_LAST)) begin
                    // Keep the grant; counter sticks at all-ones for long solo owners.
                    if (hold_cnt != HOLD_SAT) begin
                        next_hold_cnt = hold_cnt + CNT_W'(1);
                    end
                end else if (others) begin
                    // Release with contention or hold limit reached: hand over.
                    next_owner    = pick_idx;
                    next_ptr      = ch_idx_t'(pick_idx + 2'd1);
                    next_hold_cnt = '0;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        next_gnt = (next_state == GRANT) ? 4'(4'b0001 << next_owner) : 4'b0000;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            sel       <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= next_state;
            owner     <= next_owner;
            ptr       <= next_ptr;
            hold_cnt  <= next_hold_cnt;
            gnt       <= next_gnt;
            sel       <= next_owner;
            gnt_valid <= (next_state == GRANT);
        end
    end

endmodule
